coin_sprite_engine: RTL and testbench

Animation and address-generation stage for one spinning coin. It sits directly upstream of the four coin-frame sprite ROMs (20x20, 400 entries, palette-mapped 24-bit output) and directly downstream of their colour outputs. It converts the VGA scan position into a ROM read address and selects the current spin frame. It then returns a registered, transparency-masked coin pixel to the colour mapper. A small state machine runs the coin lifecycle: hidden, spinning, and collected (pop-up then vanish).

---
 rtl/coin_sprite_if.sv | 31 +++
 rtl/coin_sprite_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_coin_sprite_engine.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_sprite_if.sv
// Pixel/ROM bundle between the video pipeline and the coin sprite engine.
// The master side owns the scan position, coin placement, lifecycle
// requests and the four frame ROMs; the slave side is the engine itself.
interface coin_sprite_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  coin_x;
  logic [9:0]  coin_y;
  logic        spawn;
  logic        collect;
  logic [23:0] rom_color_0;
  logic [23:0] rom_color_1;
  logic [23:0] rom_color_2;
  logic [23:0] rom_color_3;
  logic [8:0]  read_address;
  logic        coin_on;
  logic [23:0] coin_color;
  logic        busy;

  modport master (
    output DrawX, DrawY, coin_x, coin_y, spawn, collect,
    output rom_color_0, rom_color_1, rom_color_2, rom_color_3,
    input  read_address, coin_on, coin_color, busy
  );

  modport slave (
    input  DrawX, DrawY, coin_x, coin_y, spawn, collect,
    input  rom_color_0, rom_color_1, rom_color_2, rom_color_3,
    output read_address, coin_on, coin_color, busy
  );
endinterface

// File: rtl/coin_sprite_engine.sv
// Spinning-coin animation and ROM address generation.
// Turns the scan position into a shared frame-ROM address, picks the current
// spin frame, and returns a registered, transparency-masked coin pixel two
// Clk cycles after the scan position. A small FSM runs the coin lifecycle:
// hidden, spinning, collected (rise and vanish).
module coin_sprite_engine #(
  parameter int          SPRITE_W    = 20,
  parameter int          SPRITE_H    = 20,
  parameter int          FRAME_DIV   = 8,
  parameter int          POP_FRAMES  = 16,
  parameter int          POP_STEP    = 2,
  parameter logic [23:0] TRANSPARENT = 24'h800080
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  coin_sprite_if.slave  bus
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int CNT_W = (POP_FRAMES > 1) ? $clog2(POP_FRAMES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(POP_FRAMES - 1);
  localparam logic [9:0]        POP_INC  = 10'(POP_STEP);
  localparam logic [10:0]       SW11     = 11'(SPRITE_W);
  localparam logic signed [11:0] SH12    = 12'(SPRITE_H);
  localparam logic [8:0]        SW9      = 9'(SPRITE_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPIN,
    S_COLLECTED
  } state_t;

  // ---------------------------------------------------------------------
  // frame_clk synchroniser and rising-edge tick
  // ---------------------------------------------------------------------
  logic fc_meta;
  logic fc_sync;
  logic fc_prev;
  logic tick;

  // Two-flop synchroniser, an edge-detect flop, and a registered one-cycle tick.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware shift chain.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_meta <= 1'b0;
      fc_sync <= 1'b0;
      fc_prev <= 1'b0;
      tick    <= 1'b0;
    end else begin
      fc_meta <= frame_clk;
      fc_sync <= fc_meta;
      fc_prev <= fc_sync;
      tick    <= fc_sync & ~fc_prev;
    end
  end

  // ---------------------------------------------------------------------
  // Lifecycle FSM
  // ---------------------------------------------------------------------
  state_t           state;
  logic [1:0]       frame;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] tick_cnt;
  logic [9:0]       pop_offset;
  logic             busy_q;

  // Lifecycle: spawn starts the spin, collect starts the pop-up, and the
  // pop-up retires itself after POP_FRAMES ticks. busy is set/cleared on the
  // same edge as the state so it never lags the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      frame      <= 2'd0;
      div        <= '0;
      tick_cnt   <= '0;
      pop_offset <= 10'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // spawn beats a simultaneous collect here: collect only means
          // something once the coin is spinning.
          if (bus.spawn) begin
            state      <= S_SPIN;
            frame      <= 2'd0;
            div        <= '0;
            pop_offset <= 10'd0;
            busy_q     <= 1'b1;
          end
        end
        S_SPIN: begin
          // collect beats a tick arriving on the same cycle.
          if (bus.collect) begin
            state      <= S_COLLECTED;
            pop_offset <= 10'd0;
            tick_cnt   <= '0;
          end else if (tick) begin
            if (div == DIV_LAST) begin
              div   <= '0;
              frame <= frame + 2'd1;
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        S_COLLECTED: begin
          if (tick) begin
            frame      <= frame + 2'd1;
            pop_offset <= pop_offset + POP_INC;
            if (tick_cnt == CNT_LAST) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;

  // ---------------------------------------------------------------------
  // Stage 1: bounding box and ROM address
  // ---------------------------------------------------------------------
  logic [10:0]        x_ext;
  logic [10:0]        cx_ext;
  logic signed [11:0] top;
  logic signed [11:0] y_rel;
  logic [8:0]         x_off;
  logic [8:0]         y_off;
  logic               in_x;
  logic               in_y;
  logic               in_box;
  logic               visible;
  logic [8:0]         addr_calc;

  // Geometry of the current scan pixel against the (possibly risen) coin.
  // Y is carried as 12-bit signed so a coin risen above the screen top clips
  // instead of wrapping, and top+SPRITE_H near the bottom edge cannot overflow.
  // NOTE: every signal written in always_comb gets a value on every path
  // (here by straight-line assignment), so no latch can be inferred.
  always_comb begin
    x_ext     = {1'b0, bus.DrawX};
    cx_ext    = {1'b0, bus.coin_x};
    top       = signed'({2'b00, bus.coin_y}) - signed'({2'b00, pop_offset});
    y_rel     = signed'({2'b00, bus.DrawY}) - top;
    in_x      = (x_ext >= cx_ext) && (x_ext < cx_ext + SW11);
    in_y      = (y_rel >= 12'sd0) && (y_rel < SH12);
    in_box    = in_x && in_y;
    visible   = (state != S_IDLE);
    x_off     = 9'(x_ext - cx_ext);
    y_off     = 9'(y_rel);
    addr_calc = y_off * SW9 + x_off;
  end

  logic [8:0] read_address_q;
  logic [1:0] frame_d;
  logic       in_box_d;
  logic       visible_d;

  // Stage-1 register: address to the ROMs plus the qualifiers that travel
  // alongside it. A hidden coin parks the ROMs at address 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address_q <= 9'd0;
      frame_d        <= 2'd0;
      in_box_d       <= 1'b0;
      visible_d      <= 1'b0;
    end else begin
      read_address_q <= (in_box && visible) ? addr_calc : 9'd0;
      frame_d        <= frame;
      in_box_d       <= in_box;
      visible_d      <= visible;
    end
  end

  assign bus.read_address = read_address_q;

  // ---------------------------------------------------------------------
  // Stage 2: frame select, transparency mask, output register
  // ---------------------------------------------------------------------
  logic [23:0] rom_sel;
  logic        opaque;

  // Pick the ROM belonging to the frame that produced this address.
  always_comb begin
    rom_sel = bus.rom_color_0;
    case (frame_d)
      2'd1:    rom_sel = bus.rom_color_1;
      2'd2:    rom_sel = bus.rom_color_2;
      2'd3:    rom_sel = bus.rom_color_3;
      default: rom_sel = bus.rom_color_0;
    endcase
    opaque = in_box_d && visible_d && (rom_sel != TRANSPARENT);
  end

  logic        coin_on_q;
  logic [23:0] coin_color_q;

  // Stage-2 register: colour is forced to 0 whenever the pixel is not coin.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      coin_on_q    <= 1'b0;
      coin_color_q <= 24'd0;
    end else begin
      coin_on_q    <= opaque;
      coin_color_q <= opaque ? rom_sel : 24'd0;
    end
  end

  assign bus.coin_on    = coin_on_q;
  assign bus.coin_color = coin_color_q;

endmodule

// File: tb/tb_coin_sprite_engine.sv
// Self-checking bench for coin_sprite_engine: directed lifecycle scenarios
// followed by randomized scan/lifecycle traffic, all compared every cycle
// against a behavioural model built from tick counts and pixel arithmetic.
module tb_coin_sprite_engine;

  localparam int          SPRITE_W   = 20;
  localparam int          SPRITE_H   = 20;
  localparam int          FRAME_DIV  = 8;
  localparam int          POP_FRAMES = 16;
  localparam int          POP_STEP   = 2;
  localparam logic [23:0] TRANSP     = 24'h800080;
  localparam logic [23:0] C_FRAME [4] = '{24'h00A000, 24'h0000F0, 24'hF0F000, 24'h10E0E0};

  logic Clk       = 1'b0;
  logic Reset     = 1'b1;
  logic frame_clk = 1'b0;

  coin_sprite_if bus();

  coin_sprite_engine dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  // Behavioural frame ROMs, read combinationally at the DUT's address.
  logic [23:0] rom [4][512];
  assign bus.rom_color_0 = rom[0][bus.read_address];
  assign bus.rom_color_1 = rom[1][bus.read_address];
  assign bus.rom_color_2 = rom[2][bus.read_address];
  assign bus.rom_color_3 = rom[3][bus.read_address];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: lifecycle as tick counters, pixel as arithmetic.
  // ------------------------------------------------------------------
  typedef struct {
    bit in_box;
    bit vis;
    int frame;
    int addr;
  } px_t;

  int          m_phase;      // 0 hidden, 1 spinning, 2 popping up
  int          m_spin_ticks; // ticks seen while spinning since spawn
  int          m_pop_ticks;  // ticks seen since collect
  int          m_base;       // frame shown at the moment of collect
  bit          fcq[$];       // frame_clk samples, newest first
  px_t         s1;           // pixel the DUT is fetching right now
  bit          exp_on;
  logic [23:0] exp_col;

  function automatic int model_frame();
    if (m_phase == 1) return (m_spin_ticks / FRAME_DIV) % 4;
    return (m_base + m_pop_ticks) % 4;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_spin_ticks = 0; m_pop_ticks = 0; m_base = 0;
    fcq = '{0, 0, 0, 0};
    s1 = '{0, 0, 0, 0};
    exp_on = 1'b0;
    exp_col = 24'd0;
  endtask

  // One Clk edge of the model, evaluated with the inputs present at that edge.
  task automatic model_edge();
    bit  tick;
    px_t nxt;
    int  dx, dy, top;
    // A frame_clk rise takes effect three edges after it is first sampled.
    tick = fcq[2] && !fcq[3];
    top  = int'(bus.coin_y) - POP_STEP * m_pop_ticks;
    dx   = int'(bus.DrawX) - int'(bus.coin_x);
    dy   = int'(bus.DrawY) - top;
    nxt.vis    = (m_phase != 0);
    nxt.in_box = (dx >= 0) && (dx < SPRITE_W) && (dy >= 0) && (dy < SPRITE_H);
    nxt.frame  = model_frame();
    nxt.addr   = (nxt.in_box && nxt.vis) ? dy * SPRITE_W + dx : 0;
    exp_on  = s1.in_box && s1.vis && (rom[s1.frame][s1.addr] != TRANSP);
    exp_col = exp_on ? rom[s1.frame][s1.addr] : 24'd0;
    s1 = nxt;
    case (m_phase)
      0: if (bus.spawn) begin
        m_phase = 1; m_spin_ticks = 0; m_pop_ticks = 0; m_base = 0;
      end
      1: if (bus.collect) begin
        m_base = (m_spin_ticks / FRAME_DIV) % 4;
        m_phase = 2; m_pop_ticks = 0;
      end else if (tick) begin
        m_spin_ticks++;
      end
      default: if (tick) begin
        m_pop_ticks++;
        if (m_pop_ticks == POP_FRAMES) m_phase = 0;
      end
    endcase
    fcq.push_front(frame_clk);
    void'(fcq.pop_back());
  endtask

  // Advance one cycle and compare every output at the following negedge.
  task automatic cycle();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check("addr", 32'(bus.read_address), 32'(s1.addr));
    check("coin_on", 32'(bus.coin_on), 32'(exp_on));
    check("coin_color", 32'(bus.coin_color), 32'(exp_col));
    check("busy", 32'(bus.busy), 32'(m_phase != 0));
  endtask

  task automatic set_px(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      cycle(); cycle();
      frame_clk = 1'b0;
      repeat (3) cycle();
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once.
  task automatic reset_mid();
    #2 Reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_coin_on", 32'(bus.coin_on), 32'd0);
    check("rst_addr", 32'(bus.read_address), 32'd0);
    check("rst_color", 32'(bus.coin_color), 32'd0);
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic logic [23:0] opaque_colour();
    logic [23:0] v;
    do v = 24'($urandom); while (v == TRANSP);
    return v;
  endfunction

  initial begin
    int x, y;
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 512; a++) rom[k][a] = opaque_colour();
    for (int k = 0; k < 4; k++) rom[k][0] = C_FRAME[k];
    bus.spawn = 1'b0; bus.collect = 1'b0;
    bus.coin_x = 10'd100; bus.coin_y = 10'd200;
    set_px(0, 0);
    model_reset();

    // Reset held for three cycles: everything quiet.
    repeat (3) begin
      @(negedge Clk);
      check("reset_addr", 32'(bus.read_address), 32'd0);
      check("reset_on", 32'(bus.coin_on), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
    end
    Reset = 1'b0;

    // Idle sweep over the coin box.
    for (int i = 0; i < 24; i++) begin
      set_px(98 + i, 198 + i);
      cycle();
    end

    // Spawn and address map corners.
    bus.spawn = 1'b1; cycle(); bus.spawn = 1'b0;
    set_px(100, 200); cycle();
    check("addr_origin", 32'(bus.read_address), 32'd0);
    set_px(119, 219); cycle();
    check("addr_last", 32'(bus.read_address), 32'd399);
    set_px(120, 219); cycle(); cycle();
    check("right_edge_off", 32'(bus.coin_on), 32'd0);

    // Frame advance: 8 ticks per frame while spinning.
    set_px(100, 200);
    pulse(8); cycle();
    check("frame1_color", 32'(bus.coin_color), 32'(C_FRAME[1]));
    pulse(24); cycle();
    check("frame0_again", 32'(bus.coin_color), 32'(C_FRAME[0]));

    // Transparency key.
    rom[0][0] = TRANSP; cycle(); cycle();
    check("transparent_off", 32'(bus.coin_on), 32'd0);
    rom[0][0] = 24'hF83800; cycle(); cycle();
    check("opaque_on", 32'(bus.coin_on), 32'd1);
    check("opaque_color", 32'(bus.coin_color), 32'hF83800);

    // Collect: rises POP_STEP per tick and advances a frame per tick.
    bus.collect = 1'b1; cycle(); bus.collect = 1'b0;
    pulse(3);
    set_px(100, 194); cycle();
    check("pop_addr", 32'(bus.read_address), 32'd0);
    cycle();
    check("pop_frame3", 32'(bus.coin_color), 32'(C_FRAME[3]));
    pulse(13);
    check("pop_done_busy", 32'(bus.busy), 32'd0);
    cycle(); cycle();
    check("pop_done_on", 32'(bus.coin_on), 32'd0);

    // spawn and collect together while hidden: spawn wins, coin spins.
    bus.spawn = 1'b1; bus.collect = 1'b1; cycle();
    bus.spawn = 1'b0; bus.collect = 1'b0;
    check("spawn_wins", 32'(bus.busy), 32'd1);
    pulse(1);
    set_px(101, 200); cycle();
    check("spin_not_pop", 32'(bus.read_address), 32'd1);

    // Clipping above the screen top, then reset during the pop-up.
    bus.coin_y = 10'd10;
    bus.collect = 1'b1; cycle(); bus.collect = 1'b0;
    pulse(8);
    set_px(100, 0); cycle();
    check("clip_addr", 32'(bus.read_address), 32'd120);
    cycle();
    reset_mid();
    cycle();
    check("after_rst_busy", 32'(bus.busy), 32'd0);

    // Randomized traffic with transparent pixels sprinkled in the ROMs.
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 512; a++)
        rom[k][a] = ($urandom_range(0, 3) == 0) ? TRANSP : opaque_colour();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        bus.coin_x = 10'($urandom_range(0, 1023));
        bus.coin_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 30))
                                                 : 10'($urandom_range(0, 1023));
      end
      x = int'(bus.coin_x) + int'($urandom_range(0, 25)) - 3;
      y = int'(bus.coin_y) - POP_STEP * m_pop_ticks + int'($urandom_range(0, 25)) - 3;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      set_px(x, y);
      bus.spawn   = ($urandom_range(0, 39) == 0);
      bus.collect = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 999) == 0) reset_mid();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
